// File: rtl/mix_accum_sequencer.sv
// Audio frame mixer: time-multiplexes one external 12-bit adder to sum VOICES
// snapshotted voice samples with saturation, producing one registered mix per frame.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for sample_tick; adder operands held at 0
// SUM   | one voice added per cycle, idx walks 0..VOICES-1
// DONE  | accumulator final; next edge publishes mix_out/clip/mix_valid
module mix_accum_sequencer #(
    parameter int VOICES = 4,
    parameter int IDX_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_tick,
    input  logic [12*VOICES-1:0]  voice_data,
    input  logic [VOICES-1:0]     voice_en,
    output logic [11:0]           add_lhs,
    output logic [11:0]           add_rhs,
    input  logic [11:0]           add_result,
    input  logic                  add_overflow,
    output logic [11:0]           mix_out,
    output logic                  mix_valid,
    output logic                  busy,
    output logic                  clip,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUM  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VOICES - 1);

    state_e                 state_q, state_d;
    logic [11:0]            acc_q, acc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [12*VOICES-1:0]   data_snap_q, data_snap_d;
    logic [VOICES-1:0]      en_snap_q, en_snap_d;
    logic                   clip_work_q, clip_work_d;
    logic [11:0]            mix_out_q, mix_out_d;
    logic                   clip_q, clip_d;
    logic                   mix_valid_q, mix_valid_d;
    logic                   overrun_q, overrun_d;

    logic [11:0]            voice_sel;
    logic                   voice_sel_en;

    // Mux decoded by comparison so non-power-of-two VOICES never index past the snapshot.
    always_comb begin
        voice_sel    = 12'd0;
        voice_sel_en = 1'b0;
        for (int i = 0; i < VOICES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                voice_sel    = data_snap_q[12*i +: 12];
                voice_sel_en = en_snap_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        data_snap_d = data_snap_q;
        en_snap_d   = en_snap_q;
        clip_work_d = clip_work_q;
        mix_out_d   = mix_out_q;
        clip_d      = clip_q;
        mix_valid_d = 1'b0;
        overrun_d   = 1'b0;
        add_lhs     = 12'd0;
        add_rhs     = 12'd0;
        busy        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    data_snap_d = voice_data;
                    en_snap_d   = voice_en;
                    acc_d       = 12'd0;
                    idx_d       = '0;
                    clip_work_d = 1'b0;
                    state_d     = ST_SUM;
                end
            end
            ST_SUM: begin
                busy        = 1'b1;
                overrun_d   = sample_tick;
                add_lhs     = acc_q;
                add_rhs     = voice_sel_en ? voice_sel : 12'd0;
                // Saturation is sticky: at 0xFFF any nonzero add carries out again.
                acc_d       = add_overflow ? 12'hFFF : add_result;
                clip_work_d = clip_work_q | add_overflow;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                overrun_d   = sample_tick;
                mix_out_d   = acc_q;
                clip_d      = clip_work_q;
                mix_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= 12'd0;
            idx_q       <= '0;
            data_snap_q <= '0;
            en_snap_q   <= '0;
            clip_work_q <= 1'b0;
            mix_out_q   <= 12'd0;
            clip_q      <= 1'b0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            data_snap_q <= data_snap_d;
            en_snap_q   <= en_snap_d;
            clip_work_q <= clip_work_d;
            mix_out_q   <= mix_out_d;
            clip_q      <= clip_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mix_out   = mix_out_q;
    assign clip      = clip_q;
    assign mix_valid = mix_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mix_accum_sequencer.sv
// Bench for mix_accum_sequencer: directed scenarios plus random frames checked
// against a saturating-sum reference model.
module tb_mix_accum_sequencer;

    localparam int V  = 4;
    localparam int IW = 2;

    logic            clk;
    logic            rst_n;
    logic            sample_tick;
    logic [12*V-1:0] voice_data;
    logic [V-1:0]    voice_en;
    logic [11:0]     add_lhs;
    logic [11:0]     add_rhs;
    logic [11:0]     add_result;
    logic            add_overflow;
    logic [11:0]     mix_out;
    logic            mix_valid;
    logic            busy;
    logic            clip;
    logic            overrun;

    mix_accum_sequencer #(.VOICES(V), .IDX_W(IW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_tick  (sample_tick),
        .voice_data   (voice_data),
        .voice_en     (voice_en),
        .add_lhs      (add_lhs),
        .add_rhs      (add_rhs),
        .add_result   (add_result),
        .add_overflow (add_overflow),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .busy         (busy),
        .clip         (clip),
        .overrun      (overrun)
    );

    // External combinational adder.
    assign {add_overflow, add_result} = {1'b0, add_lhs} + {1'b0, add_rhs};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] vd [V];
    logic [V-1:0] ven;
    logic [11:0] last_mix = 12'd0;
    logic        last_clip = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_voices();
        for (int i = 0; i < V; i++) voice_data[12*i +: 12] = vd[i];
        voice_en = ven;
    endtask

    // Frame result from the rules: true sum of enabled voices, clamped to 12 bits.
    task automatic ref_frame(output logic [11:0] mix, output logic c);
        int total;
        total = 0;
        for (int i = 0; i < V; i++) if (ven[i]) total += int'(vd[i]);
        c   = (total > 4095);
        mix = c ? 12'hFFF : total[11:0];
    endtask

    // Runs one frame from the vd/ven arrays. Returns at the negedge where mix_valid is high.
    // immediate: raise tick at the current negedge instead of waiting one.
    // ovr: second tick plus new voice_data two cycles after the first tick.
    task automatic do_frame(input bit immediate, input bit ovr);
        int          pre;
        logic [11:0] em;
        logic        ec;
        ref_frame(em, ec);
        pre = 0;
        if (!immediate) @(negedge clk);
        drive_voices();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        for (int i = 0; i < V; i++) begin
            if (ovr && i == 1) begin
                sample_tick = 1'b1;
                for (int j = 0; j < V; j++) voice_data[12*j +: 12] = 12'($urandom);
                voice_en = V'($urandom);
            end
            if (ovr && i == 2) sample_tick = 1'b0;
            chk($sformatf("sum_busy[%0d]", i), 32'(busy), 32'd1);
            chk($sformatf("sum_lhs[%0d]", i), 32'(add_lhs), (pre > 4095) ? 32'hFFF : 32'(pre));
            chk($sformatf("sum_rhs[%0d]", i), 32'(add_rhs), ven[i] ? 32'(vd[i]) : 32'd0);
            chk($sformatf("sum_overrun[%0d]", i), 32'(overrun), (ovr && i == 2) ? 32'd1 : 32'd0);
            chk($sformatf("sum_valid[%0d]", i), 32'(mix_valid), 32'd0);
            if (ven[i]) pre += int'(vd[i]);
            @(negedge clk);
        end
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_valid", 32'(mix_valid), 32'd0);
        chk("done_lhs", 32'(add_lhs), 32'd0);
        @(negedge clk);
        chk("valid_pulse", 32'(mix_valid), 32'd1);
        chk("mix_out", 32'(mix_out), 32'(em));
        chk("clip", 32'(clip), 32'(ec));
        chk("valid_busy", 32'(busy), 32'd0);
        chk("valid_overrun", 32'(overrun), 32'd0);
        last_mix  = em;
        last_clip = ec;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_valid", 32'(mix_valid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_overrun", 32'(overrun), 32'd0);
            chk("idle_mix_hold", 32'(mix_out), 32'(last_mix));
            chk("idle_clip_hold", 32'(clip), 32'(last_clip));
            chk("idle_lhs", 32'(add_lhs), 32'd0);
            chk("idle_rhs", 32'(add_rhs), 32'd0);
        end
    endtask

    task automatic set_voices(input logic [11:0] a, input logic [11:0] b,
                              input logic [11:0] c, input logic [11:0] d,
                              input logic [V-1:0] e);
        vd[0] = a; vd[1] = b; vd[2] = c; vd[3] = d; ven = e;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        sample_tick = 1'b0;
        voice_data  = '0;
        voice_en    = '0;
        set_voices(12'd0, 12'd0, 12'd0, 12'd0, 4'b0000);
        repeat (3) @(negedge clk);
        chk("rst_mix_out", 32'(mix_out), 32'd0);
        chk("rst_valid", 32'(mix_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clip", 32'(clip), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_lhs", 32'(add_lhs), 32'd0);
        chk("rst_rhs", 32'(add_rhs), 32'd0);
        rst_n = 1'b1;
        idle_check(2);

        // Basic sum, then enable masking.
        set_voices(12'd100, 12'd200, 12'd300, 12'd400, 4'b1111);
        do_frame(1'b0, 1'b0);
        chk("basic_value", 32'(mix_out), 32'h3E8);
        idle_check(2);
        set_voices(12'd100, 12'd200, 12'd300, 12'd400, 4'b0101);
        do_frame(1'b0, 1'b0);
        chk("mask_value", 32'(mix_out), 32'd400);
        idle_check(1);

        // Saturation, then clip replaced by a clean frame.
        set_voices(12'hF00, 12'h200, 12'h050, 12'h001, 4'b1111);
        do_frame(1'b0, 1'b0);
        chk("sat_value", 32'(mix_out), 32'hFFF);
        chk("sat_clip", 32'(clip), 32'd1);
        idle_check(1);
        set_voices(12'd1, 12'd1, 12'd1, 12'd1, 4'b1111);
        do_frame(1'b0, 1'b0);
        chk("ones_value", 32'(mix_out), 32'd4);
        chk("ones_clip", 32'(clip), 32'd0);
        idle_check(1);

        // All voices disabled.
        set_voices(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4'b0000);
        do_frame(1'b0, 1'b0);
        chk("alloff_value", 32'(mix_out), 32'd0);
        idle_check(1);

        // Overrun with snapshot protection; ignored tick must not start a frame.
        set_voices(12'd11, 12'd22, 12'd33, 12'd44, 4'b1111);
        do_frame(1'b0, 1'b1);
        chk("ovr_value", 32'(mix_out), 32'd110);
        idle_check(4);

        // Back-to-back: second tick during the mix_valid cycle.
        set_voices(12'd5, 12'd6, 12'd7, 12'd8, 4'b1111);
        do_frame(1'b0, 1'b0);
        set_voices(12'd1000, 12'd1000, 12'd1000, 12'd1000, 4'b1110);
        do_frame(1'b1, 1'b0);
        chk("b2b_value", 32'(mix_out), 32'd3000);
        idle_check(1);

        // Saturating frame so reset visibly clears mix_out and clip.
        set_voices(12'hFFF, 12'h001, 12'h000, 12'h000, 4'b1111);
        do_frame(1'b0, 1'b0);
        @(negedge clk);
        set_voices(12'd3, 12'd4, 12'd5, 12'd6, 4'b1111);
        drive_voices();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_lhs", 32'(add_lhs), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("midrst_mix_out", 32'(mix_out), 32'd0);
        chk("midrst_clip", 32'(clip), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(mix_valid), 32'd0);
        chk("midrst_lhs", 32'(add_lhs), 32'd0);
        chk("midrst_rhs", 32'(add_rhs), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_mix  = 12'd0;
        last_clip = 1'b0;
        idle_check(8);
        do_frame(1'b0, 1'b0);
        chk("post_rst_value", 32'(mix_out), 32'd18);
        idle_check(1);

        // Random frames with mixed magnitudes and occasional back-to-back ticks.
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < V; i++)
                vd[i] = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 4095))
                                                    : 12'($urandom_range(0, 900));
            ven = V'($urandom);
            do_frame(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) != 0) idle_check(int'($urandom_range(1, 3)));
        end
        idle_check(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
